// File: rtl/decode_pkg.sv
// Shared types and constants for the instruction decode stage.
//   - RV32 opcode constants and the CSRRW funct3 encoding
//   - inst_type_t: 3-bit instruction class
//   - bundle_t:    decoded bundle held in the stage's registers
package decode_pkg;

  // The imm field is sized for the widest legal XLEN. Narrower
  // instances ignore the upper half.
  localparam int unsigned MaxXlen = 64;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcSystem = 7'b1110011;
  localparam logic [6:0] OpcStore  = 7'b0100011;

  localparam logic [2:0] F3Csrrw = 3'b001;

  typedef enum logic [2:0] {
    TypeR       = 3'd0,
    TypeI       = 3'd1,
    TypeU       = 3'd2,
    TypeCsrrw   = 3'd3,
    TypeS       = 3'd4,
    TypeIllegal = 3'd7
  } inst_type_t;

  typedef struct packed {
    inst_type_t         itype;
    logic [MaxXlen-1:0] imm;
    logic [11:0]        csr_addr;
    logic [6:0]         funct7;
    logic [2:0]         funct3;
    logic [4:0]         rd;
    logic [4:0]         rs2;
    logic [4:0]         rs1;
  } bundle_t;

endpackage

// File: rtl/decode_stage_if.sv
// Handshake and bundle signals of the decode stage.
//   Upstream:   in_valid, in_inst -> stage; in_ready <- stage
//   Downstream: out_valid and decoded fields <- stage; out_ready -> stage
//   Status:     illegal_cnt <- stage
// Modport slave is the stage side. Modport master is the environment side.
interface decode_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);

  logic             in_valid;
  logic [31:0]      in_inst;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [4:0]       out_rd;
  logic [2:0]       out_funct3;
  logic [6:0]       out_funct7;
  logic [XLEN-1:0]  out_imm;
  logic [11:0]      out_csr_addr;
  logic [2:0]       out_type;
  logic [CNT_W-1:0] illegal_cnt;

  modport slave (
    input  in_valid, in_inst, out_ready,
    output in_ready, out_valid, out_rs1, out_rs2, out_rd, out_funct3, out_funct7,
           out_imm, out_csr_addr, out_type, illegal_cnt
  );

  modport master (
    output in_valid, in_inst, out_ready,
    input  in_ready, out_valid, out_rs1, out_rs2, out_rd, out_funct3, out_funct7,
           out_imm, out_csr_addr, out_type, illegal_cnt
  );

endinterface

// File: rtl/inst_field_decode.sv
// Combinational RV32 field decoder.
//   inst_i   : 32-bit instruction word
//   bundle_o : class, immediate and raw field slices
// The immediate is extended to XLEN (32 or 64). Bits above XLEN are zero.
module inst_field_decode
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0] inst_i,
  output bundle_t     bundle_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];

  always_comb begin
    bundle_o          = '0;
    // The field slices pass through unchanged for every class.
    bundle_o.rs1      = inst_i[19:15];
    bundle_o.rs2      = inst_i[24:20];
    bundle_o.rd       = inst_i[11:7];
    bundle_o.funct3   = funct3;
    bundle_o.funct7   = inst_i[31:25];
    bundle_o.csr_addr = inst_i[31:20];
    bundle_o.itype    = TypeIllegal;
    bundle_o.imm      = '0;

    case (opcode)
      OpcOp: begin
        bundle_o.itype = TypeR;
      end
      OpcOpImm: begin
        bundle_o.itype = TypeI;
        bundle_o.imm   = {{52{inst_i[31]}}, inst_i[31:20]};
      end
      OpcLui: begin
        bundle_o.itype = TypeU;
        bundle_o.imm   = {{32{inst_i[31]}}, inst_i[31:12], 12'b0};
      end
      OpcStore: begin
        bundle_o.itype = TypeS;
        bundle_o.imm   = {{52{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      end
      OpcSystem: begin
        // Only CSRRW is supported. Other SYSTEM encodings are illegal.
        if (funct3 == F3Csrrw) begin
          bundle_o.itype = TypeCsrrw;
          bundle_o.imm   = {52'b0, inst_i[31:20]};
        end
      end
      default: ;
    endcase

    if (XLEN == 32) begin
      bundle_o.imm[MaxXlen-1:32] = '0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage with a two-entry output buffer.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : decode_stage_if.slave carrying the upstream and downstream
//                handshakes, the decoded bundle and the illegal-word counter
// Words are decoded before they are registered. The output register drives
// the bundle. A skid register catches a word accepted while the output is
// stalled. in_ready is a flop that is set when the skid is empty, so
// out_ready has no combinational path to in_ready.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,  // 32 or 64
  parameter int unsigned CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_stage_if.slave bus
);

  bundle_t          dec;
  bundle_t          out_q, out_d;
  bundle_t          skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             drain;

  inst_field_decode #(
    .XLEN(XLEN)
  ) u_field_decode (
    .inst_i   (bus.in_inst),
    .bundle_o (dec)
  );

  assign accept = bus.in_valid && in_ready_q;
  assign drain  = out_valid_q && bus.out_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;

    if (!out_valid_q || drain) begin
      // The output slot frees this cycle. The older skid entry goes first.
      // in_ready is low while the skid is full, so accept cannot be set here.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end

    if (drain && (out_q.itype == TypeIllegal) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_rs1      = out_q.rs1;
  assign bus.out_rs2      = out_q.rs2;
  assign bus.out_rd       = out_q.rd;
  assign bus.out_funct3   = out_q.funct3;
  assign bus.out_funct7   = out_q.funct7;
  assign bus.out_imm      = out_q.imm[XLEN-1:0];
  assign bus.out_csr_addr = out_q.csr_addr;
  assign bus.out_type     = out_q.itype;
  assign bus.illegal_cnt  = cnt_q;

endmodule
